// File: rtl/mem_if_pkg.sv
// Shared definitions for the single-port data-memory interface and its initiators.
// Holds the default bus widths and the copy-engine state encoding.
package mem_if_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port data-memory bus: the initiator drives address/data/strobes and the memory
// returns combinational read data.
interface mem_copy_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memReadData;

    modport master (
        output memAddress,
        output memWriteData,
        output memRead,
        output memWrite,
        input  memReadData
    );

    modport slave (
        input  memAddress,
        input  memWriteData,
        input  memRead,
        input  memWrite,
        output memReadData
    );

endinterface

// File: rtl/mem_copy_addr_gen.sv
// Source/destination pointer generator for the copy engine: picks the copy direction
// at load time and steps both pointers together, wrapping modulo 2**ADDR_W.
module mem_copy_addr_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] src_ptr_d,
    output logic [ADDR_W-1:0] dst_ptr_d
);

    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic              backward_q;
    logic              backward_d;
    logic [ADDR_W-1:0] len_ext;
    logic [ADDR_W:0]   src_end;

    always_comb begin
        len_ext    = ADDR_W'(length);
        // One extra bit so a block that wraps past the top of memory still compares correctly
        src_end    = {1'b0, src_addr} + {1'b0, len_ext};
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        backward_d = backward_q;
        if (load) begin
            backward_d = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
            if (backward_d) begin
                src_ptr_d = src_addr + len_ext - ADDR_W'(1);
                dst_ptr_d = dst_addr + len_ext - ADDR_W'(1);
            end else begin
                src_ptr_d = src_addr;
                dst_ptr_d = dst_addr;
            end
        end else if (step) begin
            if (backward_q) begin
                src_ptr_d = src_ptr_q - ADDR_W'(1);
                dst_ptr_d = dst_ptr_q - ADDR_W'(1);
            end else begin
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            backward_q <= 1'b0;
        end else begin
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            backward_q <= backward_d;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Memory-to-memory block copy initiator with memmove semantics: one read then one write
// per word, with start/abort control and a completion pulse.
module mem_copy_engine
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  wordsDone,
    mem_copy_engine_if.master mem
);

    mem_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              step;
    logic [ADDR_W-1:0] src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_d;

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .load      (load),
        .step      (step),
        .src_addr  (srcAddr),
        .dst_addr  (dstAddr),
        .length    (length),
        .src_ptr_d (src_ptr_d),
        .dst_ptr_d (dst_ptr_d)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    len_d   = length;
                    words_d = '0;
                    state_d = (length == '0) ? DONE : RD;
                end
            end
            RD: begin
                buf_d   = mem.memReadData;
                state_d = WR;
            end
            WR: begin
                step    = 1'b1;
                words_d = words_q + LEN_W'(1);
                state_d = (words_d == len_q) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            step    = 1'b0;
            words_d = words_q;
            buf_d   = buf_q;
        end

        // Strobes and address are registered from the next state so they line up with it
        rd_d   = (state_d == RD);
        wr_d   = (state_d == WR);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == RD) begin
            addr_d = src_ptr_d;
        end else if (state_d == WR) begin
            addr_d = dst_ptr_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // abort has to suppress the write in the very cycle it is raised
    assign mem.memWrite     = wr_q & ~abort;
    assign mem.memRead      = rd_q;
    assign mem.memAddress   = addr_q;
    assign mem.memWriteData = buf_q;
    assign busy             = busy_q;
    assign done             = done_q & ~abort;
    assign wordsDone        = words_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a memmove-level model predicts every cycle of
// bus activity and the final memory image; directed literal checks pin the model.
module tb_mem_copy_engine;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 6;

    typedef struct {
        logic          first;
        logic          busy;
        logic          done;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [LW-1:0] words;
    } rec_t;

    logic          CLK;
    logic          RESET_N;
    logic          start;
    logic          abort;
    logic [AW-1:0] srcAddr;
    logic [AW-1:0] dstAddr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [LW-1:0] wordsDone;

    mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .start     (start),
        .abort     (abort),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .wordsDone (wordsDone),
        .mem       (mif)
    );

    logic [DW-1:0] mem [64];
    logic [DW-1:0] exp_mem [64];
    logic          load_req;
    rec_t          exp_q [$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            done_cycle = 0;
    int            wr_count = 0;
    logic [AW-1:0] first_wr = '1;
    logic [LW-1:0] idle_words = '0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory: combinational read, write on rising edge, reloaded with data[i]=i on request
    assign mif.memReadData = mem[mif.memAddress[5:0]];
    always @(posedge CLK) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        end else if (mif.memWrite) begin
            mem[mif.memAddress[5:0]] = mif.memWriteData;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        rec_t r;
        if (!RESET_N) idle_words = '0;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            if (r.first) begin
                cyc = 0; done_cycle = 0; wr_count = 0; first_wr = '1;
            end
            cyc++;
            chk("busy", busy, r.busy);
            chk("done", done, r.done);
            chk("memRead", mif.memRead, r.rd);
            chk("memWrite", mif.memWrite, r.wr);
            chk("wordsDone", wordsDone, r.words);
            if (r.rd || r.wr) chk("memAddress", mif.memAddress, r.addr);
            if (r.wr) chk("memWriteData", mif.memWriteData, r.wdata);
            idle_words = r.words;
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_memRead", mif.memRead, 0);
            chk("idle_memWrite", mif.memWrite, 0);
            chk("idle_wordsDone", wordsDone, idle_words);
        end
        if (mif.memWrite) begin
            if (wr_count == 0) first_wr = mif.memAddress;
            wr_count++;
        end
        if (done) done_cycle = cyc;
    end

    task automatic do_reset();
        RESET_N = 1'b0; load_req = 1'b1; start = 1'b0; abort = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #2;
        RESET_N = 1'b1; load_req = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge CLK);
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge CLK);
        #2;
    endtask

    // kind: 0 none, 1 abort in cycle k, 2 extra start in cycle k, 3 reset in cycle k
    task automatic run_transfer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input int unsigned len, input int unsigned kind,
                                input int unsigned k);
        rec_t          lst [$];
        rec_t          r;
        logic [DW-1:0] snap [64];
        logic [AW:0]   s_end;
        logic          bw;
        int unsigned   idx;
        int            bad;

        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        s_end = {1'b0, src} + (AW + 1)'(len);
        bw = (dst > src) && ({1'b0, dst} < s_end);
        for (int unsigned n = 0; n < len; n++) begin
            idx = bw ? (len - 1 - n) : n;
            r = '{first: 1'b0, busy: 1'b1, done: 1'b0, rd: 1'b1, wr: 1'b0,
                  addr: src + AW'(idx), wdata: '0, words: LW'(n)};
            lst.push_back(r);
            r.rd = 1'b0; r.wr = 1'b1; r.addr = dst + AW'(idx);
            r.wdata = snap[(src + AW'(idx)) % 64];
            lst.push_back(r);
        end
        r = '{first: 1'b0, busy: 1'b1, done: 1'b1, rd: 1'b0, wr: 1'b0,
              addr: '0, wdata: '0, words: LW'(len)};
        lst.push_back(r);
        if (kind == 1) begin
            while (lst.size() > k) void'(lst.pop_back());
            lst[k-1].wr = 1'b0;
            lst[k-1].done = 1'b0;
        end else if (kind == 3) begin
            while (lst.size() > k - 1) void'(lst.pop_back());
        end
        lst[0].first = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = snap[i];
        foreach (lst[i]) if (lst[i].wr) exp_mem[lst[i].addr % 64] = lst[i].wdata;

        srcAddr = src; dstAddr = dst; length = LW'(len); start = 1'b1;
        @(posedge CLK);
        #2;
        start = 1'b0;
        foreach (lst[i]) exp_q.push_back(lst[i]);

        if (kind != 0) begin
            if (k > 1) begin
                repeat (k - 1) @(posedge CLK);
                #2;
            end
            if (kind == 1) begin
                abort = 1'b1;
                @(posedge CLK);
                #2;
                abort = 1'b0;
            end else if (kind == 2) begin
                srcAddr = 40; dstAddr = 50; length = 5; start = 1'b1;
                @(posedge CLK);
                #2;
                start = 1'b0;
            end else begin
                exp_q.delete();
                RESET_N = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_memRead", mif.memRead, 0);
                chk("rst_memWrite", mif.memWrite, 0);
                chk("rst_memAddress", mif.memAddress, 0);
                chk("rst_memWriteData", mif.memWriteData, 0);
                chk("rst_wordsDone", wordsDone, 0);
                repeat (2) @(posedge CLK);
                #2;
                RESET_N = 1'b1;
            end
        end
        wait_idle();
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    initial begin
        RESET_N = 1'b0; load_req = 1'b1; start = 1'b0; abort = 1'b0;
        srcAddr = '0; dstAddr = '0; length = '0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_memAddress", mif.memAddress, 0);
        chk("reset_memWriteData", mif.memWriteData, 0);
        chk("reset_wordsDone", wordsDone, 0);
        do_reset();

        // Plain forward copy
        run_transfer(2, 10, 4, 0, 0);
        chk("t1_done_cycle", done_cycle, 9);
        chk("t1_wordsDone", wordsDone, 4);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[10+i], 2 + i);

        // Overlap with dst above src must copy backward
        do_reset();
        run_transfer(0, 2, 4, 0, 0);
        chk("t2_first_wr", first_wr, 5);
        for (int i = 0; i < 4; i++) chk("t2_mem", mem[2+i], i);

        // Overlap with dst below src stays forward
        do_reset();
        run_transfer(4, 2, 3, 0, 0);
        chk("t3_first_wr", first_wr, 2);
        for (int i = 0; i < 3; i++) chk("t3_mem", mem[2+i], 4 + i);

        // Zero length, start while busy, abort together with start in IDLE
        do_reset();
        run_transfer(9, 30, 0, 0, 0);
        chk("t4_done_cycle", done_cycle, 1);
        chk("t4_wr_count", wr_count, 0);
        chk("t4_wordsDone", wordsDone, 0);
        run_transfer(1, 7, 3, 2, 2);
        chk("t4_done_cycle2", done_cycle, 7);
        for (int i = 0; i < 3; i++) chk("t4_mem", mem[7+i], 1 + i);
        chk("t4_mem50", mem[50], 50);
        srcAddr = 3; dstAddr = 33; length = 2; start = 1'b1; abort = 1'b1;
        @(posedge CLK);
        #2;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk("t4_abort_start_busy", busy, 0);
        chk("t4_abort_start_mem", mem[33], 33);

        // Abort during the second write
        do_reset();
        run_transfer(2, 20, 4, 1, 4);
        chk("t5_mem20", mem[20], 2);
        chk("t5_mem21", mem[21], 21);
        chk("t5_wordsDone", wordsDone, 1);
        chk("t5_done_cycle", done_cycle, 0);

        // Reset mid-transfer, then a fresh transfer
        do_reset();
        run_transfer(2, 30, 4, 3, 3);
        chk("t6_mem30", mem[30], 2);
        chk("t6_mem31", mem[31], 31);
        run_transfer(2, 10, 4, 0, 0);
        chk("t6_done_cycle", done_cycle, 9);
        for (int i = 0; i < 4; i++) chk("t6_mem", mem[10+i], 2 + i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
